button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
- REQ-001 The block SHALL have parameter TICK_N, default 16, giving a time tick of 2^TICK_N clk_i cycles (1.31 ms at 50 MHz).
- REQ-002 The block SHALL have parameter LONG_T, default 200, giving the long-press threshold in ticks (8-bit, 1..255).
- REQ-003 The block SHALL have parameter DBL_T, default 100, giving the double-click window in ticks (8-bit, 1..255).
- REQ-004 The block SHALL have parameter RPT_T, default 40, giving the auto-repeat period in ticks (8-bit, 1..255).
- REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
- REQ-006 The block SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
- REQ-007 The block SHALL have port push_i, input, 1 bit: debounced button level from the upstream debouncer, synchronous to clk_i.
- REQ-008 The block SHALL have port click_o, output, 1 bit: single-click pulse.
- REQ-009 The block SHALL have port dclick_o, output, 1 bit: double-click pulse.
- REQ-010 The block SHALL have port long_o, output, 1 bit: long-press pulse.
- REQ-011 The block SHALL have port rpt_o, output, 1 bit: auto-repeat pulse.
- REQ-012 The block SHALL have port held_o, output, 1 bit: level that is high while the FSM is in the PRESS1, PRESS2 or LONG state.

Function
- REQ-013 All outputs SHALL be registered; click_o, dclick_o, long_o and rpt_o SHALL each be exactly one cycle wide, and at most one of them SHALL be high in any cycle.
- REQ-014 A registered copy push_q SHALL detect a rising edge as push_i & ~push_q.
- REQ-015 A TICK_N-bit prescaler pre and an 8-bit tick counter tcnt SHALL run; tick = (pre all-ones); tcnt SHALL increment on tick.
- REQ-016 Both pre and tcnt SHALL clear on every state transition, so each timeout is exactly N*2^TICK_N cycles after entering the state.
- REQ-017 FSM states SHALL be IDLE, PRESS1, WAIT2, PRESS2, LONG.
- REQ-018 IDLE SHALL go to PRESS1 on a rising edge only; a level held high SHALL NOT trigger.
- REQ-019 PRESS1: push_i=0 -> WAIT2; else tick with tcnt==LONG_T-1 -> LONG and long_o=1 on the next cycle.
- REQ-020 WAIT2: push_i=1 -> PRESS2 and dclick_o=1 on the next cycle; else tick with tcnt==DBL_T-1 -> IDLE and click_o=1 on the next cycle.
- REQ-021 PRESS2: push_i=0 -> IDLE; PRESS2 SHALL have no timeout and no long detection.
- REQ-022 LONG: push_i=0 -> IDLE with no pulse.
- REQ-023 If a release coincides with LONG_T expiry in PRESS1, the release SHALL win (go to WAIT2, no long_o).
- REQ-024 If a press coincides with DBL_T expiry in WAIT2, the press SHALL win (dclick_o, no click_o).
- REQ-025 tcnt SHALL never wrap; the thresholds it is compared against are all at most 255.

Reset
- REQ-026 When rst_ni=0 at a clk_i edge, the FSM SHALL enter IDLE, pre=0, tcnt=0, and push_q=1.
- REQ-027 Reset SHALL drive click_o, dclick_o, long_o, rpt_o and held_o to 0.
- REQ-028 Reset mid-operation SHALL abort any pending event with no pulse emitted.
- REQ-029 Because push_q resets to 1, a button held through reset SHALL be ignored until it is released.

Configuration
- REQ-030 When macro BTN_AUTO_REPEAT_EN is defined: in LONG, each tick with tcnt==RPT_T-1 SHALL pulse rpt_o on the next cycle and clear tcnt and pre, repeating until release.
- REQ-031 When BTN_AUTO_REPEAT_EN is undefined: rpt_o SHALL be constant 0 and LONG SHALL wait only for release.

Verification (TICK_N=2, LONG_T=4, DBL_T=3, RPT_T=2)
- REQ-032 Single click: push_i high 5 cycles, then low -> exactly one click_o, 12 cycles after WAIT2 entry; no other pulses.
- REQ-033 Double click: press 5 cycles, low 4 cycles, high again -> dclick_o one cycle after second press seen; no click_o; held_o high until release.
- REQ-034 Long press: push_i held 40 cycles -> long_o 16 cycles after PRESS1 entry; with BTN_AUTO_REPEAT_EN, rpt_o every 8 cycles thereafter; without it, rpt_o stays 0.
- REQ-035 Tie cases: release on the LONG_T expiry cycle -> no long_o, later click_o; press on the DBL_T expiry cycle -> dclick_o, no click_o.
- REQ-036 Reset: rst_ni low for 1 cycle in WAIT2 -> no click_o; push_i held high through reset -> no event until release and a new press.

Source files
------------

// File: rtl/button_event.sv
// Button gesture decoder: turns a debounced level into click / double-click / long-press / repeat pulses.
// Latency: every output is registered; a pulse appears in the cycle the FSM enters its new state.
// Backpressure: none; pulses are fire-and-forget, one cycle wide, mutually exclusive.
//
// Ports:
//   clk_i    - single clock
//   rst_ni   - synchronous active-low reset
//   push_i   - debounced button level, synchronous to clk_i
//   click_o  - single-click pulse
//   dclick_o - double-click pulse
//   long_o   - long-press pulse
//   rpt_o    - auto-repeat pulse (constant 0 unless BTN_AUTO_REPEAT_EN is defined)
//   held_o   - high while the FSM is in PRESS1, PRESS2 or LONG
//
// Build option: define BTN_AUTO_REPEAT_EN to emit rpt_o every RPT_T ticks while in LONG.
module button_event #(
    parameter int unsigned TICK_N = 16,     // tick = 2^TICK_N clk_i cycles
    parameter logic [7:0]  LONG_T = 8'd200, // long-press threshold, ticks
    parameter logic [7:0]  DBL_T  = 8'd100, // double-click window, ticks
    parameter logic [7:0]  RPT_T  = 8'd40   // auto-repeat period, ticks
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    output logic click_o,
    output logic dclick_o,
    output logic long_o,
    output logic rpt_o,
    output logic held_o
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_t;

    state_t            state;
    logic [TICK_N-1:0] pre;
    logic [7:0]        tcnt;
    logic              push_q;

    logic tick;
    logic rise;

    assign tick = &pre;
    // push_q resets high so a button held through reset never looks like a new press.
    assign rise = push_i & ~push_q;

`ifndef BTN_AUTO_REPEAT_EN
    assign rpt_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            pre      <= '0;
            tcnt     <= 8'd0;
            push_q   <= 1'b1;
            click_o  <= 1'b0;
            dclick_o <= 1'b0;
            long_o   <= 1'b0;
            held_o   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_o    <= 1'b0;
`endif
        end else begin
            push_q   <= push_i;
            click_o  <= 1'b0;
            dclick_o <= 1'b0;
            long_o   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_o    <= 1'b0;
`endif
            // Free-running timebase; the clears below override these on a
            // transition so every timeout is measured from state entry.
            pre <= pre + 1'b1;
            if (tick && tcnt != 8'hFF) begin
                tcnt <= tcnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state  <= PRESS1;
                        pre    <= '0;
                        tcnt   <= 8'd0;
                        held_o <= 1'b1;
                    end
                end
                PRESS1: begin
                    // Release is tested first so it wins over a coincident expiry.
                    if (!push_i) begin
                        state  <= WAIT2;
                        pre    <= '0;
                        tcnt   <= 8'd0;
                        held_o <= 1'b0;
                    end else if (tick && tcnt == LONG_T - 8'd1) begin
                        state  <= LONG;
                        pre    <= '0;
                        tcnt   <= 8'd0;
                        long_o <= 1'b1;
                    end
                end
                WAIT2: begin
                    // Press is tested first so it wins over a coincident expiry.
                    if (push_i) begin
                        state    <= PRESS2;
                        pre      <= '0;
                        tcnt     <= 8'd0;
                        dclick_o <= 1'b1;
                        held_o   <= 1'b1;
                    end else if (tick && tcnt == DBL_T - 8'd1) begin
                        state   <= IDLE;
                        pre     <= '0;
                        tcnt    <= 8'd0;
                        click_o <= 1'b1;
                    end
                end
                PRESS2: begin
                    if (!push_i) begin
                        state  <= IDLE;
                        pre    <= '0;
                        tcnt   <= 8'd0;
                        held_o <= 1'b0;
                    end
                end
                LONG: begin
                    if (!push_i) begin
                        state  <= IDLE;
                        pre    <= '0;
                        tcnt   <= 8'd0;
                        held_o <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
                    end else if (tick && tcnt == RPT_T - 8'd1) begin
                        // Restart the period in place; the state itself does not change.
                        pre   <= '0;
                        tcnt  <= 8'd0;
                        rpt_o <= 1'b1;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    pre    <= '0;
                    tcnt   <= 8'd0;
                    held_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event with a small tick (TICK_N=2) so every timeout is a few cycles.
// Inputs change on the falling edge; outputs are compared on the falling edge against
// a cycle-count model of the gesture rules plus hand-computed pulse times.
module tb_button_event;

    localparam int P  = 4;   // cycles per tick (2^2)
    localparam int LT = 4;
    localparam int DT = 3;
    localparam int RT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic push  = 1'b0;
    logic click, dclick, lng, rpt, held;

    button_event #(
        .TICK_N(2),
        .LONG_T(8'd4),
        .DBL_T (8'd3),
        .RPT_T (8'd2)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .click_o (click),
        .dclick_o(dclick),
        .long_o  (lng),
        .rpt_o   (rpt),
        .held_o  (held)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // ---------------- behavioural model ----------------
    // Tracks the gesture phase and the number of whole cycles spent in it;
    // a timeout of N ticks fires on the cycle where that count reaches N*P-1.
    typedef enum {M_IDLE, M_P1, M_W2, M_P2, M_LONG} mst_t;
    mst_t m_st   = M_IDLE;
    int   m_cyc  = 0;
    logic m_prev = 1'b1;
    logic m_click = 1'b0, m_dclick = 1'b0, m_long = 1'b0, m_rpt = 1'b0, m_held = 1'b0;

    always @(posedge clk) begin : model
        mst_t nxt;
        logic c, d, l, r;
        nxt = m_st;
        c = 1'b0; d = 1'b0; l = 1'b0; r = 1'b0;
        if (!rst_n) begin
            m_st <= M_IDLE; m_cyc <= 0; m_prev <= 1'b1;
            m_click <= 1'b0; m_dclick <= 1'b0; m_long <= 1'b0; m_rpt <= 1'b0; m_held <= 1'b0;
        end else begin
            case (m_st)
                M_IDLE: if (push && !m_prev) nxt = M_P1;
                M_P1:   if (!push) nxt = M_W2;
                        else if (m_cyc == LT*P-1) begin nxt = M_LONG; l = 1'b1; end
                M_W2:   if (push) begin nxt = M_P2; d = 1'b1; end
                        else if (m_cyc == DT*P-1) begin nxt = M_IDLE; c = 1'b1; end
                M_P2:   if (!push) nxt = M_IDLE;
                M_LONG: begin
                    if (!push) nxt = M_IDLE;
`ifdef BTN_AUTO_REPEAT_EN
                    else if (m_cyc == RT*P-1) r = 1'b1;
`endif
                end
                default: nxt = M_IDLE;
            endcase
            m_prev   <= push;
            m_st     <= nxt;
            m_cyc    <= (nxt != m_st || r) ? 0 : m_cyc + 1;
            m_click  <= c;
            m_dclick <= d;
            m_long   <= l;
            m_rpt    <= r;
            m_held   <= (nxt == M_P1 || nxt == M_P2 || nxt == M_LONG);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at edge %0d", name, act, exp, edge_n);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int cnt_click = 0, cnt_dclick = 0, cnt_long = 0, cnt_rpt = 0, cnt_held = 0;
    int t_click = -1, t_dclick = -1, t_long = -1, t_rpt = -1;

    always @(negedge clk) begin
        if (edge_n > 0) begin
            chk("click_o",  click,  m_click);
            chk("dclick_o", dclick, m_dclick);
            chk("long_o",   lng,    m_long);
            chk("rpt_o",    rpt,    m_rpt);
            chk("held_o",   held,   m_held);
            chk("one_hot_pulse", (int'(click) + int'(dclick) + int'(lng) + int'(rpt)) > 1, 1'b0);
            if (click  === 1'b1) begin cnt_click++;  t_click  = edge_n; end
            if (dclick === 1'b1) begin cnt_dclick++; t_dclick = edge_n; end
            if (lng    === 1'b1) begin cnt_long++;   t_long   = edge_n; end
            if (rpt    === 1'b1) begin cnt_rpt++;    t_rpt    = edge_n; end
            if (held   === 1'b1) cnt_held++;
        end
    end

    // ---------------- stimulus ----------------
    int t0;
    int b_click, b_dclick, b_long, b_rpt, b_held;

    // Drive push for n sampling edges; caller is at a falling edge.
    task automatic hold(input logic v, input int n);
        repeat (n) begin
            push = v;
            @(negedge clk);
        end
    endtask

    task automatic snap();
        b_click = cnt_click; b_dclick = cnt_dclick; b_long = cnt_long;
        b_rpt = cnt_rpt; b_held = cnt_held;
        t0 = edge_n;
    endtask

    task automatic pulse_counts(input string tag, input int ec, input int ed, input int el, input int er);
        chk_int({tag, "_click_n"},  cnt_click  - b_click,  ec);
        chk_int({tag, "_dclick_n"}, cnt_dclick - b_dclick, ed);
        chk_int({tag, "_long_n"},   cnt_long   - b_long,   el);
        chk_int({tag, "_rpt_n"},    cnt_rpt    - b_rpt,    er);
    endtask

    initial begin
        rst_n = 1'b0;
        push  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_click",  click,  1'b0);
        chk("rst_dclick", dclick, 1'b0);
        chk("rst_long",   lng,    1'b0);
        chk("rst_rpt",    rpt,    1'b0);
        chk("rst_held",   held,   1'b0);
        rst_n = 1'b1;
        hold(1'b0, 5);

        // Single click: WAIT2 entered at edge t0+6, click 12 cycles later.
        snap();
        hold(1'b1, 5);
        hold(1'b0, 20);
        pulse_counts("single", 1, 0, 0, 0);
        chk_int("single_click_time", t_click - t0, 18);

        // Double click: second press sampled at edge t0+10.
        snap();
        hold(1'b1, 5);
        hold(1'b0, 4);
        hold(1'b1, 3);
        chk("dbl_held_in_press2", held, 1'b1);
        hold(1'b1, 3);
        hold(1'b0, 10);
        chk("dbl_held_after_release", held, 1'b0);
        pulse_counts("double", 0, 1, 0, 0);
        chk_int("double_dclick_time", t_dclick - t0, 10);

        // Long press: PRESS1 entered at edge t0+1, long_o at t0+17.
        snap();
        hold(1'b1, 40);
        hold(1'b0, 10);
        chk_int("long_long_time", t_long - t0, 17);
`ifdef BTN_AUTO_REPEAT_EN
        pulse_counts("long", 0, 0, 1, 2);
        chk_int("long_last_rpt_time", t_rpt - t0, 33);
`else
        pulse_counts("long", 0, 0, 1, 0);
`endif

        // Release on the exact long-press expiry edge: release wins.
        snap();
        hold(1'b1, 16);
        hold(1'b0, 20);
        pulse_counts("tie_long", 1, 0, 0, 0);
        chk_int("tie_long_click_time", t_click - t0, 29);

        // Press on the exact double-click expiry edge: press wins.
        snap();
        hold(1'b1, 5);
        hold(1'b0, 12);
        hold(1'b1, 3);
        hold(1'b0, 10);
        pulse_counts("tie_dbl", 0, 1, 0, 0);
        chk_int("tie_dbl_dclick_time", t_dclick - t0, 18);

        // One-cycle reset while waiting for a second press: no click.
        snap();
        hold(1'b1, 5);
        hold(1'b0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 20);
        pulse_counts("rst_wait2", 0, 0, 0, 0);

        // Button held through reset is ignored until released and pressed again.
        push  = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        snap();
        hold(1'b1, 10);
        pulse_counts("rst_held", 0, 0, 0, 0);
        chk_int("rst_held_held_cycles", cnt_held - b_held, 0);
        hold(1'b0, 3);
        snap();
        hold(1'b1, 5);
        hold(1'b0, 20);
        pulse_counts("after_rst", 1, 0, 0, 0);
        chk_int("after_rst_click_time", t_click - t0, 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
